// File: rtl/pipe_pkg.sv
// Shared types, default geometry and the gap-mask helper for the pipe field.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int DEF_ROWS = 16;
  localparam int DEF_COLS = 16;
  // Widest column the helper can build; real columns use the low ROWS bits.
  localparam int MAX_ROWS = 64;

  // Column mask: ones everywhere in 0..rows-1 except a gap_h-row hole.
  // The hole start folds raw values past the last legal position back into range.
  function automatic logic [MAX_ROWS-1:0] gap_mask(input logic [3:0] raw,
                                                   input int rows,
                                                   input int gap_h);
    int gmax;
    int gap_top;
    logic [MAX_ROWS-1:0] m;
    gmax    = rows - gap_h;
    gap_top = (int'(raw) < gmax) ? int'(raw) : int'(raw) - gmax;
    m       = '0;
    for (int r = 0; r < MAX_ROWS; r++) begin
      m[r] = (r < rows) && !((r >= gap_top) && (r < gap_top + gap_h));
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_column_gen.sv
// Combinational random-sample to pipe-column mask generator.
module pipe_column_gen
  import pipe_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int GAP_H = 4
) (
  input  logic [3:0]      raw,
  output logic [ROWS-1:0] mask
);

  logic [MAX_ROWS-1:0] full_mask;
  // Rows above ROWS are always zero from the helper; tied off here.
  logic                unused_hi;

  // Build the full-width mask and keep the rows this field actually has.
  always_comb begin
    full_mask = gap_mask(raw, ROWS, GAP_H);
    mask      = full_mask[ROWS-1:0];
    unused_hi = ^full_mask[MAX_ROWS-1:ROWS];
  end

endmodule

// File: rtl/pipe_scroller.sv
// Pipe field builder/scroller: FSM, spawn counter and column shift register.
module pipe_scroller
  import pipe_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int GAP_H    = 4,
  parameter int SPACING  = 6,
  parameter int BIRD_COL = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 start,
  input  logic                 crash,
  input  logic [9:0]           rnd,
  output logic [COLS*ROWS-1:0] grid,
  output logic [ROWS-1:0]      bird_col,
  output logic                 score_pulse,
  output logic                 running
);

  localparam int CNT_W = (SPACING > 2) ? $clog2(SPACING) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPACING - 1);

  state_t                 state_p1;
  logic [COLS*ROWS-1:0]   grid_p1;
  logic [CNT_W-1:0]       cnt_p1;
  logic                   pulse_p1;

  logic [ROWS-1:0]        spawn_mask;
  logic [ROWS-1:0]        insert_col;
  logic [COLS*ROWS-1:0]   grid_shifted;
  logic                   pipe_reaching_bird;
  // Only the low nibble of the LFSR picks the gap.
  logic                   unused_rnd_hi;

  pipe_column_gen #(
    .ROWS  (ROWS),
    .GAP_H (GAP_H)
  ) u_column_gen (
    .raw  (rnd[3:0]),
    .mask (spawn_mask)
  );

  // Next-column selection and the one-column-left shifted field.
  always_comb begin
    unused_rnd_hi      = ^rnd[9:4];
    insert_col         = (cnt_p1 == CNT_LAST) ? spawn_mask : '0;
    grid_shifted       = {insert_col, grid_p1[COLS*ROWS-1:ROWS]};
    pipe_reaching_bird = |grid_p1[(BIRD_COL+1)*ROWS +: ROWS];
  end

  // Game FSM with field, spawn counter and score pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1 <= IDLE;
      grid_p1  <= '0;
      cnt_p1   <= '0;
      pulse_p1 <= 1'b0;
    end else begin
      pulse_p1 <= 1'b0;
      case (state_p1)
        IDLE, HALT: begin
          if (start) begin
            state_p1 <= RUN;
            grid_p1  <= '0;
            cnt_p1   <= '0;
          end
        end
        RUN: begin
          if (crash) begin
            state_p1 <= HALT;
          end else if (tick) begin
            grid_p1  <= grid_shifted;
            cnt_p1   <= (cnt_p1 == CNT_LAST) ? '0 : cnt_p1 + 1'b1;
            pulse_p1 <= pipe_reaching_bird;
          end
        end
        default: state_p1 <= IDLE;
      endcase
    end
  end

  assign grid        = grid_p1;
  assign score_pulse = pulse_p1;
  assign bird_col    = grid_p1[BIRD_COL*ROWS +: ROWS];
  assign running     = (state_p1 == RUN);

endmodule

// File: tb/tb_pipe_scroller.sv
// Self-checking bench for pipe_scroller against a column-array reference model.
module tb_pipe_scroller;

  localparam int ROWS = 16;
  localparam int COLS = 16;

  logic                 clk = 1'b0;
  logic                 reset, tick, start, crash;
  logic [9:0]           rnd;
  logic [COLS*ROWS-1:0] grid;
  logic [ROWS-1:0]      bird_col;
  logic                 score_pulse;
  logic                 running;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: game mode, field as an array of columns, tick count.
  int          m_mode;          // 0 idle, 1 running, 2 halted
  logic [15:0] m_col [COLS];
  int          m_ticks;         // ticks since entering running
  logic        m_pulse;

  pipe_scroller dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .start       (start),
    .crash       (crash),
    .rnd         (rnd),
    .grid        (grid),
    .bird_col    (bird_col),
    .score_pulse (score_pulse),
    .running     (running)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mask(input int raw);
    int top;
    logic [15:0] m;
    top = (raw < 12) ? raw : raw - 12;
    m = 16'hFFFF;
    for (int r = top; r < top + 4; r++) m[r] = 1'b0;
    return m;
  endfunction

  function automatic logic [COLS*ROWS-1:0] model_grid();
    logic [COLS*ROWS-1:0] g;
    for (int c = 0; c < COLS; c++) g[c*ROWS +: ROWS] = m_col[c];
    return g;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one clock of inputs, advance the model, then compare all outputs.
  task automatic step(input bit r, input bit t, input bit s, input bit c, input logic [9:0] rv);
    reset = r; tick = t; start = s; crash = c; rnd = rv;
    if (r) begin
      m_mode = 0; m_ticks = 0; m_pulse = 1'b0;
      for (int i = 0; i < COLS; i++) m_col[i] = '0;
    end else begin
      m_pulse = 1'b0;
      if (m_mode != 1 && s) begin
        m_mode = 1; m_ticks = 0;
        for (int i = 0; i < COLS; i++) m_col[i] = '0;
      end else if (m_mode == 1 && c) begin
        m_mode = 2;
      end else if (m_mode == 1 && t) begin
        m_ticks++;
        m_pulse = (m_col[4] != 16'h0);
        for (int i = 0; i < COLS - 1; i++) m_col[i] = m_col[i+1];
        m_col[COLS-1] = (m_ticks % 6 == 0) ? ref_mask(int'(rv[3:0])) : 16'h0;
      end
    end
    @(posedge clk);
    #1;
    chk("grid", 256'(grid), 256'(model_grid()));
    chk("score_pulse", 256'(score_pulse), 256'(m_pulse));
    chk("running", 256'(running), 256'(m_mode == 1));
    chk("bird_col", 256'(bird_col), 256'(m_col[3]));
  endtask

  initial begin
    logic [15:0] c15;
    int zeros, first, last;

    // Reset and first spawn with rnd=5.
    step(1, 0, 0, 0, 10'h000);
    chk("reset_grid", 256'(grid), 256'h0);
    step(0, 1, 0, 0, 10'h005);                 // idle tick ignored
    step(0, 0, 1, 0, 10'h005);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 10'h005);
    chk("spawn5_col15", 256'(grid[15*ROWS +: ROWS]), 256'h0000_FE1F);
    chk("spawn5_rest", 256'(grid[15*ROWS-1:0]), 256'h0);

    // Score pulse after 18th tick, then 6 ticks later.
    for (int i = 7; i <= 17; i++) step(0, 1, 0, 0, 10'(i));
    chk("no_pulse_17", 256'(score_pulse), 256'h0);
    step(0, 1, 0, 0, 10'h000);
    chk("pulse_18", 256'(score_pulse), 256'h1);
    step(0, 0, 0, 0, 10'h000);
    chk("pulse_one_cycle", 256'(score_pulse), 256'h0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 10'h3C3);
    chk("pulse_24", 256'(score_pulse), 256'h1);

    // Crash together with tick freezes; ticks ignored; restart clears.
    step(0, 1, 0, 1, 10'h000);
    chk("crash_running", 256'(running), 256'h0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 10'h000);
    step(0, 0, 1, 0, 10'h000);
    chk("restart_grid", 256'(grid), 256'h0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 10'h00D);
    chk("spawn13_col15", 256'(grid[15*ROWS +: ROWS]), 256'h0000_FFE1);
    for (int i = 0; i < 6; i++) step(0, 1, 1'b0, 0, 10'h00B);
    chk("spawn11_col15", 256'(grid[15*ROWS +: ROWS]), 256'h0000_87FF);
    step(0, 0, 1, 0, 10'h000);                 // start while running: ignored

    // Reset mid-run with a pipe heading for the bird column.
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 10'h000);
    step(1, 1, 1, 0, 10'h000);
    chk("midreset_grid", 256'(grid), 256'h0);
    chk("midreset_pulse", 256'(score_pulse), 256'h0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 10'h000);

    // Sweep every gap nibble through a spawn.
    for (int raw = 0; raw < 16; raw++) begin
      step(1, 0, 0, 0, 10'h000);
      step(0, 0, 1, 0, 10'h000);
      for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 10'($urandom_range(0, 63) << 4) | 10'(raw));
      c15 = grid[15*ROWS +: ROWS];
      zeros = 0; first = -1; last = -1;
      for (int r = 0; r < ROWS; r++) begin
        if (!c15[r]) begin
          zeros++;
          if (first < 0) first = r;
          last = r;
        end
      end
      chk("sweep_contig", 256'((zeros == 4) && (last - first == 3)), 256'h1);
      chk("sweep_top", 256'(first), 256'((raw < 12) ? raw : raw - 12));
    end

    // Randomized mix of ticks, starts, crashes and occasional resets.
    step(1, 0, 0, 0, 10'h000);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0,
           10'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
